// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: controller in front of a single-port synchronous data RAM.
// It arbitrates the pipeline MEM stage against a debug/loader port. The pipeline
// has priority, and debug is forced in after STARVE_MAX denied cycles. Stores
// drive byte enables and lane-replicated data. Loads are extended from the
// selected lane one cycle later.
// Optional feature: define DM_ARB_PERF_CNT_EN to add the perf_stall_cnt output.
module dm_port_arbiter #(
    parameter int IDX_W      = 10,
    parameter int STARVE_MAX = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mem_ls_bit,
    input  logic             mem_we,
    input  logic             mem_ext_op,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             mem_stall,
    output logic             mem_rvalid,
    output logic [31:0]      mem_rdata,
    output logic             mem_misalign,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [31:0]      dbg_addr,
    input  logic [31:0]      dbg_wdata,
    output logic             dbg_ack,
    output logic [31:0]      dbg_rdata,
    output logic             ram_en,
    output logic [3:0]       ram_be,
    output logic [IDX_W-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata
`ifdef DM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);
    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] WORD = 2'b01;
    localparam logic [1:0] HALF = 2'b10;
    localparam logic [1:0] BYTE = 2'b11;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, P_RD, D_WAIT} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [1:0]    ld_size_q, ld_size_d, ld_off_q, ld_off_d;
    logic          ld_ext_q, ld_ext_d, dbg_we_q, dbg_we_d;

    logic          pipe_req, misalign, dbg_gnt;
    logic [3:0]    st_be;
    logic [31:0]   st_data, ld_data;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;

    // Ungated outputs; the reset gate below forces them to 0 while reset is low
    logic             stall_c, rvalid_c, mis_c, ack_c, en_c;
    logic [31:0]      rdata_c, drdata_c, wdata_c;
    logic [3:0]       be_c;
    logic [IDX_W-1:0] addr_c;

    // Address bits above the RAM index wrap and are not used
    logic unused_bits;
    assign unused_bits = &{1'b0, mem_addr[31:IDX_W+2], dbg_addr[31:IDX_W+2], dbg_addr[1:0]};

    assign pipe_req = (mem_ls_bit != NONE);
    assign misalign = ((mem_ls_bit == WORD) && (mem_addr[1:0] != 2'b00)) ||
                      ((mem_ls_bit == HALF) && mem_addr[0]);

    // Store lane decode: byte enables and replicated write data
    always_comb begin
        st_be   = 4'b0000;
        st_data = '0;
        case (mem_ls_bit)
            WORD: begin st_be = 4'b1111; st_data = mem_wdata; end
            HALF: begin
                st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{mem_wdata[15:0]}};
            end
            BYTE: begin
                st_be   = 4'b0001 << mem_addr[1:0];
                st_data = {4{mem_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and sign/zero extension, using the access latched at grant
    always_comb begin
        ld_b = ram_rdata[7:0];
        case (ld_off_q)
            2'd1:    ld_b = ram_rdata[15:8];
            2'd2:    ld_b = ram_rdata[23:16];
            2'd3:    ld_b = ram_rdata[31:24];
            default: ld_b = ram_rdata[7:0];
        endcase
        ld_h = ld_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (ld_size_q)
            BYTE:    ld_data = {{24{ld_ext_q & ld_b[7]}}, ld_b};
            HALF:    ld_data = {{16{ld_ext_q & ld_h[15]}}, ld_h};
            default: ld_data = ram_rdata;
        endcase
    end

    // Arbitration FSM: grant, RAM drive, handshake outputs and next state
    always_comb begin
        state_d   = state_q;
        ld_size_d = ld_size_q;
        ld_off_d  = ld_off_q;
        ld_ext_d  = ld_ext_q;
        dbg_we_d  = dbg_we_q;
        dbg_gnt   = 1'b0;
        stall_c   = 1'b0;
        rvalid_c  = 1'b0;
        rdata_c   = '0;
        mis_c     = 1'b0;
        ack_c     = 1'b0;
        drdata_c  = '0;
        en_c      = 1'b0;
        be_c      = 4'b0000;
        addr_c    = '0;
        wdata_c   = '0;
        case (state_q)
            IDLE: begin
                if (dbg_req && (!pipe_req || starve_q == STARVE_LIM)) begin
                    dbg_gnt  = 1'b1;
                    en_c     = 1'b1;
                    be_c     = dbg_we ? 4'b1111 : 4'b0000;
                    addr_c   = dbg_addr[IDX_W+1:2];
                    wdata_c  = dbg_we ? dbg_wdata : '0;
                    stall_c  = pipe_req;
                    dbg_we_d = dbg_we;
                    state_d  = D_WAIT;
                end else if (pipe_req) begin
                    if (misalign) begin
                        // Dropped without touching the RAM; a load still retires with 0
                        mis_c    = 1'b1;
                        rvalid_c = ~mem_we;
                    end else begin
                        en_c   = 1'b1;
                        addr_c = mem_addr[IDX_W+1:2];
                        if (mem_we) begin
                            be_c    = st_be;
                            wdata_c = st_data;
                        end else begin
                            stall_c   = 1'b1;
                            ld_size_d = mem_ls_bit;
                            ld_off_d  = mem_addr[1:0];
                            ld_ext_d  = mem_ext_op;
                            state_d   = P_RD;
                        end
                    end
                end
            end
            P_RD: begin
                rvalid_c = 1'b1;
                rdata_c  = ld_data;
                state_d  = IDLE;
            end
            D_WAIT: begin
                ack_c    = 1'b1;
                drdata_c = dbg_we_q ? '0 : ram_rdata;
                stall_c  = pipe_req;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Starvation counter: denied debug cycles, saturating, cleared on debug grant
    always_comb begin
        starve_d = starve_q;
        if (dbg_gnt)
            starve_d = '0;
        else if (dbg_req && state_q != D_WAIT && starve_q != STARVE_LIM)
            starve_d = starve_q + 1'b1;
    end

    // State and latched access registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            ld_size_q <= NONE;
            ld_off_q  <= 2'b00;
            ld_ext_q  <= 1'b0;
            dbg_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_ext_q  <= ld_ext_d;
            dbg_we_q  <= dbg_we_d;
        end
    end

    assign mem_stall    = reset & stall_c;
    assign mem_rvalid   = reset & rvalid_c;
    assign mem_misalign = reset & mis_c;
    assign dbg_ack      = reset & ack_c;
    assign ram_en       = reset & en_c;
    assign mem_rdata    = reset ? rdata_c  : '0;
    assign dbg_rdata    = reset ? drdata_c : '0;
    assign ram_be       = reset ? be_c     : '0;
    assign ram_addr     = reset ? addr_c   : '0;
    assign ram_wdata    = reset ? wdata_c  : '0;

`ifdef DM_ARB_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Free-running stall-cycle counter, wraps at 2^32
    always_comb perf_d = perf_q + {31'b0, mem_stall};

    // Stall counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a behavioural RAM, a per-cycle reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dm_port_arbiter;
    localparam int IDX_W = 10;
    localparam int SM    = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mem_ls_bit = 2'b00;
    logic        mem_we = 1'b0, mem_ext_op = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic [31:0] ram_rdata = '0;
    logic        mem_stall, mem_rvalid, mem_misalign, dbg_ack, ram_en;
    logic [31:0] mem_rdata, dbg_rdata, ram_wdata;
    logic [3:0]  ram_be;
    logic [IDX_W-1:0] ram_addr;
`ifdef DM_ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clock = ~clock;

    dm_port_arbiter #(.IDX_W(IDX_W), .STARVE_MAX(SM)) dut (
        .clock(clock), .reset(reset),
        .mem_ls_bit(mem_ls_bit), .mem_we(mem_we), .mem_ext_op(mem_ext_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_misalign(mem_misalign),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_en(ram_en), .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef DM_ARB_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] pat(int i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural single-port RAM, 1-cycle read latency
    logic [31:0] ram [0:1023];
    logic        ram_init = 1'b0;
    always @(posedge clock) begin
        if (!reset) begin
            if (!ram_init) begin
                for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
                ram[5] <= 32'h8081_F2F3;
                ram_init <= 1'b1;
            end
        end else if (ram_en) begin
            if (ram_be == 4'b0000) ram_rdata <= ram[ram_addr];
            else
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model state: phase 0 free, 1 pipeline read returning, 2 debug completing
    logic [31:0] shadow [0:1023];
    logic        sh_init = 1'b0;
    int          m_phase = 0, n_phase = 0, m_starve = 0;
    logic [1:0]  m_size = '0, m_off = '0;
    logic        m_ext = 1'b0, m_dwe = 1'b0;
    logic [9:0]  m_idx = '0;
    logic [31:0] stall_cnt = '0;
    logic        s_stall = 1'b0, s_ack = 1'b0;
    logic        e_stall, e_rvalid, e_mis, e_ack, e_en;
    logic [31:0] e_rdata, e_drdata, e_wdata, w, v;
    logic [3:0]  e_be;
    logic [9:0]  e_addr;
    logic        pipe, mis;
    logic [1:0]  off;

    // Compare every cycle's outputs against the model, then advance the model
    always @(negedge clock) begin
        e_stall = 0; e_rvalid = 0; e_rdata = 0; e_mis = 0; e_ack = 0;
        e_drdata = 0; e_en = 0; e_be = 0; e_addr = 0; e_wdata = 0;
        n_phase = 0;
        if (!reset) begin
            m_starve = 0;
            stall_cnt = 0;
            if (!sh_init) begin
                for (int i = 0; i < 1024; i++) shadow[i] = pat(i);
                shadow[5] = 32'h8081_F2F3;
                sh_init = 1'b1;
            end
        end else if (m_phase == 1) begin
            w = shadow[m_idx];
            if (m_size == 2'b11) begin
                v = (w >> (8 * m_off)) & 32'hFF;
                if (m_ext && v[7]) v = v | 32'hFFFF_FF00;
            end else if (m_size == 2'b10) begin
                v = (w >> (16 * m_off[1])) & 32'hFFFF;
                if (m_ext && v[15]) v = v | 32'hFFFF_0000;
            end else v = w;
            e_rvalid = 1; e_rdata = v;
            if (dbg_req && m_starve < SM) m_starve++;
        end else if (m_phase == 2) begin
            e_ack = 1;
            e_drdata = m_dwe ? 32'h0 : shadow[m_idx];
            e_stall = (mem_ls_bit != 0);
        end else begin
            pipe = (mem_ls_bit != 0);
            off  = mem_addr[1:0];
            mis  = (mem_ls_bit == 2'b01 && off != 0) || (mem_ls_bit == 2'b10 && off[0]);
            if (dbg_req && (!pipe || m_starve == SM)) begin
                e_en = 1; e_addr = dbg_addr[11:2]; e_stall = pipe;
                if (dbg_we) begin
                    e_be = 4'hF; e_wdata = dbg_wdata; shadow[dbg_addr[11:2]] = dbg_wdata;
                end
                m_dwe = dbg_we; m_idx = dbg_addr[11:2]; m_starve = 0; n_phase = 2;
            end else begin
                if (pipe && mis) begin
                    e_mis = 1; e_rvalid = !mem_we;
                end else if (pipe) begin
                    e_en = 1; e_addr = mem_addr[11:2];
                    if (mem_we) begin
                        case (mem_ls_bit)
                            2'b01: begin
                                e_be = 4'hF; e_wdata = mem_wdata;
                                shadow[e_addr] = mem_wdata;
                            end
                            2'b10: begin
                                e_be = off[1] ? 4'hC : 4'h3;
                                e_wdata = {mem_wdata[15:0], mem_wdata[15:0]};
                                shadow[e_addr][16*off[1] +: 16] = mem_wdata[15:0];
                            end
                            default: begin
                                e_be = 4'(1 << off);
                                e_wdata = {4{mem_wdata[7:0]}};
                                shadow[e_addr][8*off +: 8] = mem_wdata[7:0];
                            end
                        endcase
                    end else begin
                        e_stall = 1; n_phase = 1;
                        m_size = mem_ls_bit; m_ext = mem_ext_op; m_off = off; m_idx = e_addr;
                    end
                end
                if (dbg_req && m_starve < SM) m_starve++;
            end
        end
        checks++;
        if ({mem_stall, mem_rvalid, mem_rdata, mem_misalign, dbg_ack, dbg_rdata,
             ram_en, ram_be, ram_addr, ram_wdata} !==
            {e_stall, e_rvalid, e_rdata, e_mis, e_ack, e_drdata,
             e_en, e_be, e_addr, e_wdata}) begin
            errors++;
            $display("FAIL cycle@%0t: stall %b/%b rvalid %b/%b rdata %h/%h mis %b/%b ack %b/%b drdata %h/%h en %b/%b be %h/%h addr %0d/%0d wdata %h/%h (got/expected)",
                     $time, mem_stall, e_stall, mem_rvalid, e_rvalid, mem_rdata, e_rdata,
                     mem_misalign, e_mis, dbg_ack, e_ack, dbg_rdata, e_drdata,
                     ram_en, e_en, ram_be, e_be, ram_addr, e_addr, ram_wdata, e_wdata);
        end
`ifdef DM_ARB_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, stall_cnt);
`endif
        if (reset) stall_cnt = stall_cnt + {31'b0, e_stall};
        m_phase = reset ? n_phase : 0;
        s_stall = mem_stall;
        s_ack   = dbg_ack;
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic drive(input logic [1:0] ls, input logic we, input logic ext,
                         input logic [31:0] a, input logic [31:0] wd);
        step();
        mem_ls_bit = ls; mem_we = we; mem_ext_op = ext; mem_addr = a; mem_wdata = wd;
    endtask

    // Release the pipeline once its current access has been accepted
    task automatic idle_pipe();
        for (int i = 0; i < 10; i++) begin
            step();
            if (!s_stall) begin mem_ls_bit = 2'b00; break; end
        end
        step();
    endtask

    int ack_k;

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_stall", {31'b0, mem_stall}, 0);
        chk("reset_ram_en", {31'b0, ram_en}, 0);
        step(); reset = 1'b1;

        // 1: LB / LBU of RAM[5]
        drive(2'b11, 0, 1, 32'h14, 0);
        @(negedge clock);
        chk("lb_stall", {31'b0, mem_stall}, 1);
        chk("lb_be", {28'b0, ram_be}, 0);
        chk("lb_addr", {22'b0, ram_addr}, 5);
        step(); @(negedge clock);
        chk("lb_rvalid", {31'b0, mem_rvalid}, 1);
        chk("lb_rdata", mem_rdata, 32'hFFFF_FFF3);
        chk("lb_stall_done", {31'b0, mem_stall}, 0);
        drive(2'b11, 0, 0, 32'h14, 0);
        step(); @(negedge clock);
        chk("lbu_rdata", mem_rdata, 32'h0000_00F3);

        // 2: SH then LHU at 0x16
        drive(2'b10, 1, 0, 32'h16, 32'h0000_ABCD);
        @(negedge clock);
        chk("sh_be", {28'b0, ram_be}, 32'hC);
        chk("sh_wdata", ram_wdata, 32'hABCD_ABCD);
        chk("sh_addr", {22'b0, ram_addr}, 5);
        chk("sh_stall", {31'b0, mem_stall}, 0);
        drive(2'b10, 0, 0, 32'h16, 0);
        step(); @(negedge clock);
        chk("lhu_rdata", mem_rdata, 32'h0000_ABCD);

        // 3: misaligned LW
        drive(2'b01, 0, 0, 32'h13, 0);
        @(negedge clock);
        chk("mis_en", {31'b0, ram_en}, 0);
        chk("mis_pulse", {31'b0, mem_misalign}, 1);
        chk("mis_rvalid", {31'b0, mem_rvalid}, 1);
        chk("mis_rdata", mem_rdata, 0);
        chk("mis_stall", {31'b0, mem_stall}, 0);
        drive(2'b00, 0, 0, 0, 0);
        @(negedge clock);
        chk("mis_pulse_end", {31'b0, mem_misalign}, 0);

        // 4: back-to-back loads with debug read held until starvation forces it in
        ack_k = -1;
        for (int k = 0; k < 13; k++) begin
            step();
            if (k == 0) begin
                dbg_req = 1; dbg_we = 0; dbg_addr = 32'h1C;
                mem_ls_bit = 2'b01; mem_we = 0; mem_addr = 32'h20;
            end else if (!s_stall) mem_addr = 32'h20 + 4 * k;
            if (s_ack) dbg_req = 0;
            @(negedge clock);
            if (k == 8) begin
                chk("starve_gnt_addr", {22'b0, ram_addr}, 7);
                chk("starve_gnt_stall", {31'b0, mem_stall}, 1);
            end
            if (k == 9) begin
                chk("starve_ack_stall", {31'b0, mem_stall}, 1);
                chk("starve_ack_data", dbg_rdata, pat(7));
            end
            if (dbg_ack && ack_k < 0) ack_k = k;
        end
        chk("starve_ack_cycle", ack_k, 9);
        idle_pipe();

        // 5: reset during the read-data cycle
        drive(2'b01, 0, 0, 32'h20, 0);
        step(); reset = 1'b0; #1;
        chk("rst_rvalid", {31'b0, mem_rvalid}, 0);
        chk("rst_stall", {31'b0, mem_stall}, 0);
        mem_ls_bit = 2'b00;
        step(); step(); reset = 1'b1;
        drive(2'b01, 0, 0, 32'h14, 0);
        step(); @(negedge clock);
        chk("rst_lw_rvalid", {31'b0, mem_rvalid}, 1);
        chk("rst_lw_rdata", mem_rdata, 32'hABCD_F2F3);
        drive(2'b00, 0, 0, 0, 0);

        // Randomized traffic on both ports, including externally held requests
        for (int c = 0; c < 1500; c++) begin
            step();
            if (s_ack) dbg_req = 0;
            else if (!dbg_req && $urandom_range(0, 5) == 0) begin
                dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = $urandom; dbg_wdata = $urandom;
            end
            if (!s_stall && $urandom_range(0, 3) != 0) begin
                mem_ls_bit = 2'($urandom_range(0, 3));
                mem_we = 1'($urandom_range(0, 1));
                mem_ext_op = 1'($urandom_range(0, 1));
                mem_addr = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2)
                           | $urandom_range(0, 3);
                mem_wdata = $urandom;
            end
        end
        idle_pipe();
        dbg_req = 0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
